// File: rtl/gf180mcu_osu_sc_gp12t3v3__dffre_pipe.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_gp12t3v3__dffre_pipe
//
// Multi-bit, multi-stage register pipeline with load enable, scan shift,
// programmable reset value and per-stage valid tracking. Every data bit sits
// on a single scan chain: SI -> stage[0][0] .. stage[0][WIDTH-1] ->
// stage[1][0] .. stage[STAGES-1][WIDTH-1] -> SO.
//
// Parameters
//   WIDTH     data bits per stage (>= 1)
//   STAGES    pipeline depth (>= 1)
//   RESET_VAL value loaded into every stage while R is high
//
// Ports
//   CLK    in   1      rising-edge clock
//   R      in   1      asynchronous active-high reset
//   D      in   WIDTH  data into stage 0
//   EN     in   1      load/advance enable
//   SE     in   1      scan enable (overrides EN)
//   SI     in   1      scan input
//   Q      out  WIDTH  last-stage data
//   QN     out  WIDTH  bitwise inverse of Q
//   VALID  out  1      last-stage valid flag
//   SO     out  1      scan output (MSB of last stage)
// -----------------------------------------------------------------------------
module gf180mcu_osu_sc_gp12t3v3__dffre_pipe #(
    parameter int unsigned            WIDTH     = 4,
    parameter int unsigned            STAGES    = 2,
    parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             VALID,
    output logic             SO
);

    // Total number of storage bits on the scan chain.
    localparam int unsigned NBITS = WIDTH * STAGES;

    // All stages flattened: stage k, bit b lives at index k*WIDTH + b, so a
    // left shift by one walks the scan chain and a left shift by WIDTH
    // advances the pipeline.
    logic [NBITS-1:0]  chain_r;
    logic [NBITS-1:0]  chain_nxt_s;
    logic [NBITS-1:0]  chain_scan_s;
    logic [NBITS-1:0]  chain_adv_s;
    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] vld_nxt_s;
    logic [STAGES-1:0] vld_adv_s;
    logic [WIDTH-1:0]  qn_r;

    // Shift/advance candidates; the degenerate single-bit / single-stage
    // cases have no upper bits to carry forward.
    generate
        if (NBITS > 1) begin : g_scan_multi
            assign chain_scan_s = {chain_r[NBITS-2:0], SI};
        end else begin : g_scan_single
            assign chain_scan_s = SI;
        end

        if (STAGES > 1) begin : g_adv_multi
            assign chain_adv_s = {chain_r[NBITS-WIDTH-1:0], D};
            assign vld_adv_s   = {vld_r[STAGES-2:0], 1'b1};
        end else begin : g_adv_single
            assign chain_adv_s = D;
            assign vld_adv_s   = 1'b1;
        end
    endgenerate

    // Next-state select: scan beats advance beats hold; valid bits stay put
    // during scan because they are not part of the chain.
    always_comb begin
        chain_nxt_s = chain_r;
        vld_nxt_s   = vld_r;
        if (SE) begin
            chain_nxt_s = chain_scan_s;
            vld_nxt_s   = vld_r;
        end else if (EN) begin
            chain_nxt_s = chain_adv_s;
            vld_nxt_s   = vld_adv_s;
        end else begin
            chain_nxt_s = chain_r;
            vld_nxt_s   = vld_r;
        end
    end

    // State registers with asynchronous reset to RESET_VAL / not-valid.
    // QN is kept in its own register so it is as glitch-free as Q.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            chain_r <= {STAGES{RESET_VAL}};
            vld_r   <= {STAGES{1'b0}};
            qn_r    <= ~RESET_VAL;
        end else begin
            chain_r <= chain_nxt_s;
            vld_r   <= vld_nxt_s;
            qn_r    <= ~chain_nxt_s[NBITS-1 -: WIDTH];
        end
    end

    assign Q     = chain_r[NBITS-1 -: WIDTH];
    assign QN    = qn_r;
    assign VALID = vld_r[STAGES-1];
    assign SO    = chain_r[NBITS-1];

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__dffre_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for gf180mcu_osu_sc_gp12t3v3__dffre_pipe (WIDTH=4, STAGES=2,
// RESET_VAL=4'hA). Table-driven per-edge vectors plus hand-written
// sequences for asynchronous reset, reset/clock collision and reset mid-scan.
// -----------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_gp12t3v3__dffre_pipe;

    localparam int unsigned    WIDTH  = 4;
    localparam int unsigned    STAGES = 2;
    localparam logic [3:0]     RVAL   = 4'hA;

    logic       CLK;
    logic       R;
    logic [3:0] D;
    logic       EN;
    logic       SE;
    logic       SI;
    logic [3:0] Q;
    logic [3:0] QN;
    logic       VALID;
    logic       SO;

    int checks;
    int errors;

    typedef struct {
        logic       r;
        logic       en;
        logic       se;
        logic       si;
        logic [3:0] d;
        logic [3:0] q;
        logic       v;
    } vec_t;

    vec_t vecs [0:39];
    int   nvec;

    gf180mcu_osu_sc_gp12t3v3__dffre_pipe #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (RVAL)
    ) dut (
        .CLK   (CLK),
        .R     (R),
        .D     (D),
        .EN    (EN),
        .SE    (SE),
        .SI    (SI),
        .Q     (Q),
        .QN    (QN),
        .VALID (VALID),
        .SO    (SO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Checks all four outputs against an expected Q / VALID pair.
    task automatic chk_out(input string tag, input logic [3:0] eq, input logic ev);
        logic [3:0] eqn;
        eqn = ~eq;
        chk({tag, "_q"},     {4'h0, Q},     {4'h0, eq});
        chk({tag, "_qn"},    {4'h0, QN},    {4'h0, eqn});
        chk({tag, "_valid"}, {7'h00, VALID}, {7'h00, ev});
        chk({tag, "_so"},    {7'h00, SO},   {7'h00, eq[3]});
    endtask

    task automatic add(input logic r, input logic en, input logic se, input logic si,
                       input logic [3:0] d, input logic [3:0] q, input logic v);
        vecs[nvec].r  = r;
        vecs[nvec].en = en;
        vecs[nvec].se = se;
        vecs[nvec].si = si;
        vecs[nvec].d  = d;
        vecs[nvec].q  = q;
        vecs[nvec].v  = v;
        nvec++;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge CLK);
            R  = vecs[i].r;
            EN = vecs[i].en;
            SE = vecs[i].se;
            SI = vecs[i].si;
            D  = vecs[i].d;
            @(posedge CLK);
            #1;
            chk_out($sformatf("row%0d", i), vecs[i].q, vecs[i].v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nvec   = 0;

        // rows 0-3: advance D=1,2,3 (then 4) from reset
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'hA, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h2, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h3, 1'b1);
        // rows 4-8: prime with 9, then D=5, two stall edges, advance
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 4'hA, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h9, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 4'h5, 1'b1);
        // row 9: synchronous-looking reset edge
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 1'b0);
        // rows 10-17: scan 1,0,1,1,0,0,1,0 with EN=1 and D=F ignored
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h5, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hA, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h5, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hA, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h5, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hA, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h5, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hB, 1'b0);
        // row 18: advance after scan moves stage0 (4'b0010) to Q, VALID still 0
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h2, 1'b0);
        // rows 19-23: resume scan of zeros from the RESET_VAL contents
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hA, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hA, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0);

        R  = 1'b1;
        EN = 1'b0;
        SE = 1'b0;
        SI = 1'b0;
        D  = 4'h0;
        #1;
        chk_out("init_reset", RVAL, 1'b0);

        run_rows(0, 3);

        // Asynchronous reset while CLK is low, from Q=3 / VALID=1.
        @(negedge CLK);
        #2;
        R = 1'b1;
        #1;
        chk_out("async_reset", RVAL, 1'b0);

        run_rows(4, 18);

        // Reset released in the same timestep as the rising edge: reset edge.
        @(negedge CLK);
        R  = 1'b1;
        EN = 1'b1;
        SE = 1'b0;
        D  = 4'h7;
        @(posedge CLK);
        #0 R = 1'b0;
        #1;
        chk_out("collide_edge", RVAL, 1'b0);
        @(posedge CLK);
        #1;
        chk_out("collide_next", RVAL, 1'b0);
        @(negedge CLK);
        D = 4'h0;
        @(posedge CLK);
        #1;
        chk_out("collide_cap", 4'h7, 1'b1);

        // Three scan edges of ones, then reset mid-cycle.
        @(negedge CLK);
        SE = 1'b1;
        EN = 1'b0;
        SI = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #2;
        R = 1'b1;
        #1;
        chk_out("midscan_reset", RVAL, 1'b0);

        run_rows(19, 23);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
